// File: rtl/spi_rom_burst_master.sv
// SPI mode-0 burst master: reads NUM_BYTES bytes from a combinational ROM
// starting at START_ADDR and shifts each one out MSB first on MOSI, while
// capturing one byte from MISO for every byte sent.
module spi_rom_burst_master #(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned NUM_BYTES  = 4,
  parameter logic [7:0]  START_ADDR = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic       spi_cs_n,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic [7:0] rx_data,
  output logic       rx_valid
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV) + 1;
  localparam int unsigned CNT_W = $clog2(NUM_BYTES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SHIFT  = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       bit_cnt;
  logic [CNT_W-1:0] byte_cnt;
  logic [6:0]       tx_sh;   // bits still to send after the one on MOSI
  logic [7:0]       rx_sh;

  // Burst sequencer, SCLK divider and both shift registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rom_addr <= START_ADDR;
      spi_cs_n <= 1'b1;
      spi_sclk <= 1'b0;
      spi_mosi <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      done     <= 1'b0;
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            rom_addr <= START_ADDR;
            busy     <= 1'b1;
            spi_cs_n <= 1'b0;
            byte_cnt <= '0;
          end
        end
        LOAD: begin
          spi_mosi <= rom_data[7];
          tx_sh    <= rom_data[6:0];
          div_cnt  <= '0;
          bit_cnt  <= '0;
          state    <= SHIFT;
        end
        SHIFT: begin
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + DIV_W'(1);
          end else begin
            div_cnt <= '0;
            if (!spi_sclk) begin
              // rising SCLK: sample the slave
              spi_sclk <= 1'b1;
              rx_sh    <= {rx_sh[6:0], spi_miso};
            end else begin
              // falling SCLK: advance MOSI or close the byte
              spi_sclk <= 1'b0;
              if (bit_cnt != 3'd7) begin
                bit_cnt  <= bit_cnt + 3'd1;
                spi_mosi <= tx_sh[6];
                tx_sh    <= {tx_sh[5:0], 1'b0};
              end else begin
                rx_data  <= rx_sh;
                rx_valid <= 1'b1;
                if ((32'(byte_cnt) + 32'd1) < NUM_BYTES) begin
                  byte_cnt <= byte_cnt + CNT_W'(1);
                  rom_addr <= rom_addr + 8'd1;
                  state    <= LOAD;
                end else begin
                  spi_cs_n <= 1'b1;
                  done     <= 1'b1;
                  state    <= FINISH;
                end
              end
            end
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_rom_burst_master.sv
// Scoreboard bench for spi_rom_burst_master: three parameterisations share a
// clock; stimulus pushes expected bytes/addresses/done cycles into queues and
// a negedge monitor pops and compares as the DUTs produce them.
module tb_spi_rom_burst_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] start_v;
  logic       slave_mode;
  logic [7:0] slave_byte;
  logic [2:0] slv_cnt;
  int         cyc = 0;

  wire [2:0] busy_v, done_v, cs_v, sclk_v, mosi_v, rxv_v;
  wire [7:0] addr_v [3];
  wire [7:0] rxd_v  [3];

  // ROM model: data = addr + 1
  wire [7:0] rom0 = addr_v[0] + 8'd1;
  wire [7:0] rom1 = addr_v[1] + 8'd1;
  wire [7:0] rom2 = addr_v[2] + 8'd1;

  // Instance 0 can talk to a slave that returns slave_byte; others loop back
  wire miso0 = slave_mode ? slave_byte[3'd7 - slv_cnt] : mosi_v[0];
  wire miso1 = mosi_v[1];
  wire miso2 = mosi_v[2];

  spi_rom_burst_master #(.CLK_DIV(2), .NUM_BYTES(4), .START_ADDR(8'h00)) dut_a (
    .clk(clk), .rst(rst), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .rom_addr(addr_v[0]), .rom_data(rom0), .spi_cs_n(cs_v[0]), .spi_sclk(sclk_v[0]),
    .spi_mosi(mosi_v[0]), .spi_miso(miso0), .rx_data(rxd_v[0]), .rx_valid(rxv_v[0]));

  spi_rom_burst_master #(.CLK_DIV(2), .NUM_BYTES(3), .START_ADDR(8'hFE)) dut_b (
    .clk(clk), .rst(rst), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .rom_addr(addr_v[1]), .rom_data(rom1), .spi_cs_n(cs_v[1]), .spi_sclk(sclk_v[1]),
    .spi_mosi(mosi_v[1]), .spi_miso(miso1), .rx_data(rxd_v[1]), .rx_valid(rxv_v[1]));

  spi_rom_burst_master #(.CLK_DIV(1), .NUM_BYTES(1), .START_ADDR(8'h00)) dut_c (
    .clk(clk), .rst(rst), .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .rom_addr(addr_v[2]), .rom_data(rom2), .spi_cs_n(cs_v[2]), .spi_sclk(sclk_v[2]),
    .spi_mosi(mosi_v[2]), .spi_miso(miso2), .rx_data(rxd_v[2]), .rx_valid(rxv_v[2]));

  // Cycle counter: number of rising edges so far
  always @(posedge clk) cyc <= cyc + 1;

  // Slave bit pointer: advances on each SCLK fall, cleared while deselected
  always @(negedge sclk_v[0] or posedge cs_v[0]) begin
    if (cs_v[0]) slv_cnt <= 3'd0;
    else         slv_cnt <= slv_cnt + 3'd1;
  end

  function automatic logic [7:0] sa(input int i);
    return (i == 1) ? 8'hFE : 8'h00;
  endfunction
  function automatic int div_of(input int i);
    return (i == 2) ? 1 : 2;
  endfunction
  function automatic int nb_of(input int i);
    return (i == 0) ? 4 : ((i == 1) ? 3 : 1);
  endfunction
  function automatic int lat_of(input int i);
    return nb_of(i) * (1 + 16 * div_of(i)) + 1;
  endfunction

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] exp_tx   [3][$];
  logic [7:0] exp_rx   [3][$];
  logic [7:0] exp_addr [3][$];
  int         exp_done [3][$];

  function automatic void chk(input string nm, input int i,
                              input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[dut%0d] @cyc %0d: got %0h required %0h", nm, i, cyc, act, exp);
    end
  endfunction

  function automatic void bad_event(input string nm, input int i);
    n_cmp++;
    n_bad++;
    $display("FAIL %s[dut%0d] @cyc %0d: got unexpected/missing event, required none", nm, i, cyc);
  endfunction

  function automatic void push_bytes(input int i, input int n, input bit slave);
    logic [7:0] a;
    for (int b = 0; b < n; b++) begin
      a = sa(i) + 8'(b);
      exp_addr[i].push_back(a);
      exp_tx[i].push_back(a + 8'd1);
      exp_rx[i].push_back(slave ? slave_byte : a + 8'd1);
    end
  endfunction

  task automatic wait_done(input int i);
    bit seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      if (done_v[i]) seen = 1'b1;
    end
    if (!seen) bad_event("done_timeout", i);
  endtask

  task automatic run_burst(input int i, input bit slave);
    int c;
    push_bytes(i, nb_of(i), slave);
    @(posedge clk); #1;
    start_v[i] = 1'b1;
    c = cyc;
    exp_done[i].push_back(c + lat_of(i));
    @(posedge clk); #1;
    start_v[i] = 1'b0;
    wait_done(i);
    repeat (4) @(posedge clk);
  endtask

  // Monitor: compares every observable event against the queues
  int         nbits    [3];
  logic [7:0] acc      [3];
  int         last_rise[3];
  int         cs_falls [3];
  logic [2:0] prev_sclk, prev_mosi, prev_done, prev_cs;
  logic       prev_rst;

  initial begin
    prev_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nbits[i] = 0; acc[i] = '0; last_rise[i] = 0; cs_falls[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (prev_rst)
          chk("reset_state", i,
              {addr_v[i], rxd_v[i], busy_v[i], cs_v[i], sclk_v[i], mosi_v[i], done_v[i], rxv_v[i]},
              {sa(i), 8'h00, 6'b010000});
        if (rst) begin
          nbits[i]    = 0;
          cs_falls[i] = 0;
        end else begin
          if (mosi_v[i] !== prev_mosi[i]) chk("mosi_change_sclk_low", i, 32'(sclk_v[i]), 32'd0);
          if (!cs_v[i] && prev_cs[i]) cs_falls[i]++;
          if (sclk_v[i] && !prev_sclk[i]) begin
            if (nbits[i] == 0) begin
              if (exp_addr[i].size() == 0) bad_event("unexpected_byte", i);
              else chk("rom_addr", i, 32'(addr_v[i]), 32'(exp_addr[i].pop_front()));
            end else begin
              chk("sclk_period", i, cyc - last_rise[i], 2 * div_of(i));
            end
            last_rise[i] = cyc;
            acc[i] = {acc[i][6:0], mosi_v[i]};
            nbits[i]++;
            if (nbits[i] == 8) begin
              nbits[i] = 0;
              if (exp_tx[i].size() == 0) bad_event("unexpected_mosi_byte", i);
              else chk("mosi_byte", i, 32'(acc[i]), 32'(exp_tx[i].pop_front()));
            end
          end
          if (rxv_v[i]) begin
            if (exp_rx[i].size() == 0) bad_event("unexpected_rx_valid", i);
            else chk("rx_data", i, 32'(rxd_v[i]), 32'(exp_rx[i].pop_front()));
          end
          if (done_v[i]) begin
            if (exp_done[i].size() == 0) bad_event("unexpected_done", i);
            else chk("done_cycle", i, cyc, exp_done[i].pop_front());
            chk("done_busy_cs", i, {busy_v[i], cs_v[i]}, 2'b11);
            chk("cs_single_select", i, cs_falls[i], 1);
            cs_falls[i] = 0;
          end
          if (prev_done[i]) chk("busy_after_done", i, 32'(busy_v[i]), 32'd0);
        end
      end
      prev_sclk = sclk_v;
      prev_mosi = mosi_v;
      prev_done = done_v;
      prev_cs   = cs_v;
      prev_rst  = rst;
    end
  end

  // Stimulus
  initial begin
    int  c;
    bit  seen;
    rst        = 1'b1;
    start_v    = 3'b000;
    slave_mode = 1'b0;
    slave_byte = 8'hA5;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // Defaults, loopback: bytes 01..04, done 133 cycles after start
    run_burst(0, 1'b0);

    // Slave returns A5 while master sends 01..04
    slave_mode = 1'b1;
    run_burst(0, 1'b1);
    slave_mode = 1'b0;

    // start held high for the whole burst, including FINISH: one burst only
    push_bytes(0, 4, 1'b0);
    @(posedge clk); #1;
    start_v[0] = 1'b1;
    c = cyc;
    exp_done[0].push_back(c + lat_of(0));
    seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(posedge clk); #1;
      if (done_v[0]) seen = 1'b1;
    end
    if (!seen) bad_event("hammer_done_timeout", 0);
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (40) @(posedge clk);
    // a fresh start after the burst is accepted
    run_burst(0, 1'b0);

    // Reset during bit 5 of byte 2: byte 1 completes, nothing else does
    exp_addr[0].push_back(8'h00);
    exp_tx[0].push_back(8'h01);
    exp_rx[0].push_back(8'h01);
    exp_addr[0].push_back(8'h01);
    @(posedge clk); #1;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (51) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (40) @(posedge clk);
    run_burst(0, 1'b0);

    // START_ADDR=FE, 3 bytes: addresses FE,FF,00 and wrap
    run_burst(1, 1'b0);

    // CLK_DIV=1, one byte: done 18 cycles after start
    run_burst(2, 1'b0);

    repeat (5) @(posedge clk);
    for (int i = 0; i < 3; i++)
      chk("queues_drained", i,
          exp_tx[i].size() + exp_rx[i].size() + exp_addr[i].size() + exp_done[i].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
